perf_counter_bank: RTL

//  Parametrised bank of event counters for the pipelined CPU, plus a warm-up flag.
//  The warm-up flag generalises the 1-bit post-reset "first cycle done" flag to an
//  N-cycle delay. The bank counts per-channel pipeline events (stall, flush, branch,

---
 rtl/perf_counter_bank_if.sv | 29 ++
 rtl/perf_counter_bank.sv | 98 +++++++++
 2 files changed

// File: rtl/perf_counter_bank_if.sv
// Purpose: control and readout signals of the performance counter bank.
// Latency: n/a (signal bundle only).
// Backpressure: none; event pulses and readout are fire-and-forget.
interface perf_counter_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int IDX_W    = 2
);
    logic                en;
    logic [CHANNELS-1:0] events;
    logic [CHANNELS-1:0] clr;
    logic [IDX_W-1:0]    rd_idx;
    logic [WIDTH-1:0]    rd_data;
    logic [CHANNELS-1:0] ovf;
    logic                ready;
    logic [WIDTH-1:0]    cycles;

    // Hazard/control side: drives event pulses and readout select.
    modport master (
        output en, events, clr, rd_idx,
        input  rd_data, ovf, ready, cycles
    );

    // Counter bank side.
    modport slave (
        input  en, events, clr, rd_idx,
        output rd_data, ovf, ready, cycles
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Purpose: per-channel pipeline event counters plus cycle counter, gated by an N-cycle post-reset warm-up flag.
// Latency: counters update at the edge after an event pulse; rd_data is registered, 1 cycle after rd_idx.
// Backpressure: none; every event pulse counts (or saturates), nothing is ever stalled.
// Build option: define PERF_CNT_SATURATE_EN to make counters and cycles hold at all-ones instead of wrapping.
module perf_counter_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int IDX_W    = 2,
    parameter int WARMUP   = 1
) (
    input logic              clk,
    input logic              reset,
    perf_counter_bank_if.slave bus
);
    logic [7:0]          warm_cnt;
    logic                ready_q;
    logic [WIDTH-1:0]    cycles_q;
    logic [WIDTH-1:0]    cnt [CHANNELS];
    logic [CHANNELS-1:0] ovf_q;
    logic [WIDTH-1:0]    rd_q;
    logic [WIDTH-1:0]    rd_mux;
    logic                cnt_go;

    // Events only count once warmed up and globally enabled.
    assign cnt_go = ready_q & bus.en;

    // Warm-up: count reset-free edges up to WARMUP; ready rises on the edge that reaches it and sticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt <= 8'd0;
            ready_q  <= 1'b0;
        end else begin
            if (warm_cnt != 8'(WARMUP))
                warm_cnt <= warm_cnt + 8'd1;
            if (warm_cnt == 8'(WARMUP - 1))
                ready_q <= 1'b1;
        end
    end

    // Free-running cycle count once ready; no overflow flag.
    always_ff @(posedge clk) begin
        if (reset)
            cycles_q <= '0;
`ifdef PERF_CNT_SATURATE_EN
        else if (ready_q && (cycles_q != '1))
            cycles_q <= cycles_q + WIDTH'(1);
`else
        else if (ready_q)
            cycles_q <= cycles_q + WIDTH'(1);
`endif
    end

    // Per-channel counters: clear beats event; overflow flag is sticky until clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++)
                cnt[i] <= '0;
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.clr[i]) begin
                    cnt[i]   <= '0;
                    ovf_q[i] <= 1'b0;
                end else if (cnt_go && bus.events[i]) begin
                    if (cnt[i] == '1) begin
                        ovf_q[i] <= 1'b1;
`ifndef PERF_CNT_SATURATE_EN
                        cnt[i]   <= '0;
`endif
                    end else begin
                        cnt[i] <= cnt[i] + WIDTH'(1);
                    end
                end
            end
        end
    end

    // Readout select; indices beyond the bank read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (bus.rd_idx == IDX_W'(i))
                rd_mux = cnt[i];
    end

    // Registered readout of the pre-update counter value.
    always_ff @(posedge clk) begin
        if (reset)
            rd_q <= '0;
        else
            rd_q <= rd_mux;
    end

    assign bus.rd_data = rd_q;
    assign bus.ovf     = ovf_q;
    assign bus.ready   = ready_q;
    assign bus.cycles  = cycles_q;
endmodule
